var_assign_decoder: RTL and testbench

- Inverse of the BCP unit's lowest-set-bit index encoder: takes variable-index requests and decodes them one-hot into the variable assignment bitmaps (assigned / value).
- Sits between the decision/implication logic and the clause evaluation datapath, which consumes the bitmaps.
- Accepts one request per cycle over a valid/ready handshake and returns a registered per-request status (ok / redundant / conflict / error) with its own valid/ready handshake.
- Maintains a running count of assigned variables.

---
 rtl/var_assign_decoder.sv | 161 ++++++++++++++++
 tb/tb_var_assign_decoder.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/var_assign_decoder.sv
// Decodes variable-index requests one-hot into the assigned/value bitmaps and returns a
// registered status per accepted request through a one-deep response register.
`ifndef VAR_NUM_DEFAULT
`define VAR_NUM_DEFAULT 8
`endif
`ifndef VAR_NUM_LOG_DEFAULT
`define VAR_NUM_LOG_DEFAULT 3
`endif

module var_assign_decoder #(
    parameter int unsigned VAR_NUM     = `VAR_NUM_DEFAULT,
    parameter int unsigned VAR_NUM_LOG = `VAR_NUM_LOG_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [VAR_NUM_LOG-1:0] req_idx,
    input  logic                   req_val,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [1:0]             resp_status,
    output logic [VAR_NUM_LOG-1:0] resp_idx,
    output logic [VAR_NUM-1:0]     assigned,
    output logic [VAR_NUM-1:0]     value,
    output logic [VAR_NUM_LOG:0]   assigned_cnt,
    output logic                   all_assigned
);

    localparam logic [1:0] OpAssign   = 2'b00;
    localparam logic [1:0] OpUnassign = 2'b01;
    localparam logic [1:0] OpClearAll = 2'b10;

    localparam logic [1:0] StatOk        = 2'b00;
    localparam logic [1:0] StatRedundant = 2'b01;
    localparam logic [1:0] StatConflict  = 2'b10;
    localparam logic [1:0] StatError     = 2'b11;

    localparam logic [0:0] StEmpty = 1'b0;
    localparam logic [0:0] StFull  = 1'b1;

    localparam logic [VAR_NUM_LOG:0] VarNumCnt = (VAR_NUM_LOG + 1)'(VAR_NUM);
    localparam logic [VAR_NUM_LOG:0] CntOne    = (VAR_NUM_LOG + 1)'(1);

    logic [0:0]             state_q, state_d;
    logic [VAR_NUM-1:0]     assigned_q, assigned_d;
    logic [VAR_NUM-1:0]     value_q, value_d;
    logic [VAR_NUM_LOG:0]   cnt_q, cnt_d;
    logic [1:0]             status_q, status_d;
    logic [VAR_NUM_LOG-1:0] ridx_q, ridx_d;

    logic                   accept;
    logic                   idx_ok;
    logic [VAR_NUM-1:0]     onehot;
    logic                   cur_assigned;
    logic                   cur_value;

    assign resp_valid   = (state_q == StFull);
    assign req_ready    = !rst && (!resp_valid || resp_ready);
    assign accept       = req_valid && req_ready;

    assign resp_status  = status_q;
    assign resp_idx     = ridx_q;
    assign assigned     = assigned_q;
    assign value        = value_q;
    assign assigned_cnt = cnt_q;
    assign all_assigned = (cnt_q == VarNumCnt);

    // Out-of-range indices decode to an all-zero mask.
    assign idx_ok = ({1'b0, req_idx} < VarNumCnt);

    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < VAR_NUM; i++) begin
            onehot[i] = (req_idx == VAR_NUM_LOG'(i));
        end
    end

    assign cur_assigned = |(assigned_q & onehot);
    assign cur_value    = |(value_q & onehot);

    always_comb begin
        assigned_d = assigned_q;
        value_d    = value_q;
        cnt_d      = cnt_q;
        status_d   = StatError;
        ridx_d     = req_idx;
        case (req_op)
            OpAssign: begin
                if (!idx_ok) begin
                    status_d = StatError;
                end else if (!cur_assigned) begin
                    assigned_d = assigned_q | onehot;
                    if (req_val) begin
                        value_d = value_q | onehot;
                    end
                    cnt_d    = cnt_q + CntOne;
                    status_d = StatOk;
                end else if (cur_value == req_val) begin
                    status_d = StatRedundant;
                end else begin
                    status_d = StatConflict;
                end
            end
            OpUnassign: begin
                if (!idx_ok) begin
                    status_d = StatError;
                end else if (cur_assigned) begin
                    assigned_d = assigned_q & ~onehot;
                    value_d    = value_q & ~onehot;
                    cnt_d      = cnt_q - CntOne;
                    status_d   = StatOk;
                end else begin
                    status_d = StatRedundant;
                end
            end
            OpClearAll: begin
                assigned_d = '0;
                value_d    = '0;
                cnt_d      = '0;
                status_d   = StatOk;
                ridx_d     = '0;
            end
            default: begin
                status_d = StatError;
            end
        endcase
    end

    // A new accept while full replaces the response that is being consumed this edge.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = StFull;
        end else if (resp_ready) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StEmpty;
            assigned_q <= '0;
            value_q    <= '0;
            cnt_q      <= '0;
            status_q   <= '0;
            ridx_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                assigned_q <= assigned_d;
                value_q    <= value_d;
                cnt_q      <= cnt_d;
                status_q   <= status_d;
                ridx_q     <= ridx_d;
            end
        end
    end

endmodule

// File: tb/tb_var_assign_decoder.sv
// Randomized and directed bench for var_assign_decoder with a queue scoreboard and a
// behavioural bitmap model; a second VAR_NUM=6 instance covers out-of-range indices.
module tb_var_assign_decoder;

    localparam int NV = 8;
    localparam int NL = 3;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_valid, req_ready, req_val;
    logic [1:0]    req_op;
    logic [NL-1:0] req_idx;
    logic          resp_valid, resp_ready;
    logic [1:0]    resp_status;
    logic [NL-1:0] resp_idx;
    logic [NV-1:0] assigned, value;
    logic [NL:0]   assigned_cnt;
    logic          all_assigned;

    var_assign_decoder #(.VAR_NUM(NV), .VAR_NUM_LOG(NL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_idx(req_idx), .req_val(req_val),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
        .resp_idx(resp_idx), .assigned(assigned), .value(value),
        .assigned_cnt(assigned_cnt), .all_assigned(all_assigned)
    );

    logic       r6_valid, r6_ready, r6_val, r6_resp_valid, r6_all;
    logic [1:0] r6_op, r6_status;
    logic [2:0] r6_idx, r6_resp_idx;
    logic [5:0] r6_assigned, r6_value;
    logic [3:0] r6_cnt;

    var_assign_decoder #(.VAR_NUM(6), .VAR_NUM_LOG(3)) dut6 (
        .clk(clk), .rst(rst), .req_valid(r6_valid), .req_ready(r6_ready),
        .req_op(r6_op), .req_idx(r6_idx), .req_val(r6_val),
        .resp_valid(r6_resp_valid), .resp_ready(1'b1), .resp_status(r6_status),
        .resp_idx(r6_resp_idx), .assigned(r6_assigned), .value(r6_value),
        .assigned_cnt(r6_cnt), .all_assigned(r6_all)
    );

    typedef struct packed {
        logic [1:0]    st;
        logic [NL-1:0] idx;
    } exp_t;

    exp_t sb_q[$];
    bit   m_asg[NV];
    bit   m_val[NV];
    bit   rand_rr = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NV-1:0] m_bits(input bit sel_val);
        logic [NV-1:0] r;
        for (int i = 0; i < NV; i++) r[i] = sel_val ? m_val[i] : m_asg[i];
        return r;
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < NV; i++) c += int'(m_asg[i]);
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NV; i++) begin
            m_asg[i] = 1'b0;
            m_val[i] = 1'b0;
        end
    endtask

    // Statuses: 0 ok, 1 redundant, 2 conflict, 3 error.
    task automatic model_apply(input logic [1:0] op, input int idx, input logic v,
                               output logic [1:0] st, output int ridx);
        ridx = idx;
        case (op)
            2'd0: begin
                if (idx >= NV) st = 2'd3;
                else if (!m_asg[idx]) begin
                    m_asg[idx] = 1'b1;
                    m_val[idx] = v;
                    st = 2'd0;
                end else st = (m_val[idx] == v) ? 2'd1 : 2'd2;
            end
            2'd1: begin
                if (idx >= NV) st = 2'd3;
                else if (m_asg[idx]) begin
                    m_asg[idx] = 1'b0;
                    m_val[idx] = 1'b0;
                    st = 2'd0;
                end else st = 2'd1;
            end
            2'd2: begin
                model_clear();
                st   = 2'd0;
                ridx = 0;
            end
            default: st = 2'd3;
        endcase
    endtask

    task automatic check_state(input string tag);
        check({tag, " assigned"}, 32'(assigned), 32'(m_bits(1'b0)));
        check({tag, " value"}, 32'(value), 32'(m_bits(1'b1)));
        check({tag, " cnt"}, 32'(assigned_cnt), 32'(m_cnt()));
        check({tag, " all_assigned"}, 32'(all_assigned), 32'(m_cnt() == NV));
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge with
    // req_valid still high so consecutive calls run back-to-back.
    task automatic issue(input logic [1:0] op, input int idx, input logic v, output int waits);
        logic [1:0] st;
        int         ridx;
        exp_t       e;
        req_valid = 1'b1;
        req_op    = op;
        req_idx   = NL'(idx);
        req_val   = v;
        waits     = 0;
        forever begin
            @(negedge clk);
            check_state("pre-accept");
            if (req_ready) break;
            waits++;
            if (waits > 40) begin
                check("accept timeout", 32'(waits), 32'(0));
                sync();
                return;
            end
        end
        model_apply(op, idx, v, st, ridx);
        e.st  = st;
        e.idx = NL'(ridx);
        sb_q.push_back(e);
        sync();
    endtask

    task automatic issue6(input logic [1:0] op, input logic [2:0] idx, input logic v,
                          input logic [1:0] exp_st, input logic [5:0] exp_asg);
        sync();
        r6_valid = 1'b1;
        r6_op    = op;
        r6_idx   = idx;
        r6_val   = v;
        @(negedge clk);
        check("n6 req_ready", 32'(r6_ready), 32'(1));
        sync();
        r6_valid = 1'b0;
        @(negedge clk);
        check("n6 resp_valid", 32'(r6_resp_valid), 32'(1));
        check("n6 status", 32'(r6_status), 32'(exp_st));
        check("n6 resp_idx", 32'(r6_resp_idx), 32'(op == 2'b10 ? 3'd0 : idx));
        check("n6 assigned", 32'(r6_assigned), 32'(exp_asg));
        check("n6 cnt", 32'(r6_cnt), 32'($countones(exp_asg)));
    endtask

    // Monitor: pops the scoreboard on every response handshake and watches stalls.
    initial begin
        logic       stalled = 1'b0;
        logic [1:0] held_st;
        logic [NL-1:0] held_idx;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                check("req_ready rule", 32'(req_ready),
                      32'(!resp_valid || resp_ready));
                check("cnt popcount", 32'(assigned_cnt), 32'($countones(assigned)));
                check("cnt bound", 32'(assigned_cnt <= NV), 32'(1));
                if (stalled && resp_valid) begin
                    check("stall status", 32'(resp_status), 32'(held_st));
                    check("stall idx", 32'(resp_idx), 32'(held_idx));
                end
                if (resp_valid && resp_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected response", 32'(1), 32'(0));
                    end else begin
                        e = sb_q.pop_front();
                        check("resp_status", 32'(resp_status), 32'(e.st));
                        check("resp_idx", 32'(resp_idx), 32'(e.idx));
                    end
                end
                stalled  = resp_valid && !resp_ready;
                held_st  = resp_status;
                held_idx = resp_idx;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rr) resp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int w;
        int r;
        model_clear();
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_op     = 2'b00;
        req_idx    = '0;
        req_val    = 1'b1;
        resp_ready = 1'b1;
        r6_valid   = 1'b0;
        r6_op      = 2'b00;
        r6_idx     = '0;
        r6_val     = 1'b0;

        repeat (3) begin
            @(negedge clk);
            check("reset req_ready", 32'(req_ready), 32'(0));
        end
        sync();
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("reset resp_valid", 32'(resp_valid), 32'(0));
        check("reset assigned", 32'(assigned), 32'(0));
        check("reset value", 32'(value), 32'(0));
        check("reset cnt", 32'(assigned_cnt), 32'(0));

        issue6(2'b00, 3'd5, 1'b1, 2'd0, 6'h20);
        issue6(2'b00, 3'd7, 1'b1, 2'd3, 6'h20);
        issue6(2'b01, 3'd6, 1'b0, 2'd3, 6'h20);
        issue6(2'b11, 3'd1, 1'b0, 2'd3, 6'h20);
        issue6(2'b01, 3'd5, 1'b0, 2'd0, 6'h00);

        sync();
        issue(2'b00, 3, 1'b1, w);
        issue(2'b00, 3, 1'b1, w);
        issue(2'b00, 3, 1'b0, w);
        req_valid = 1'b0;
        @(negedge clk);
        check("idx3 assigned", 32'(assigned), 32'h08);
        check("idx3 value", 32'(value), 32'h08);
        sync();

        issue(2'b10, 0, 1'b0, w);
        for (int i = 0; i < NV; i++) issue(2'b00, i, 1'b0, w);
        req_valid = 1'b0;
        @(negedge clk);
        check("full assigned", 32'(assigned), 32'hFF);
        check("full value", 32'(value), 32'h00);
        check("full cnt", 32'(assigned_cnt), 32'd8);
        check("full all_assigned", 32'(all_assigned), 32'd1);
        sync();
        issue(2'b01, 7, 1'b0, w);
        req_valid = 1'b0;
        @(negedge clk);
        check("unassign7 assigned", 32'(assigned), 32'h7F);
        check("unassign7 cnt", 32'(assigned_cnt), 32'd7);
        check("unassign7 all_assigned", 32'(all_assigned), 32'd0);

        // Backpressure: hold the response for three cycles with a second request waiting.
        repeat (2) sync();
        resp_ready = 1'b0;
        issue(2'b00, 2, 1'b1, w);
        req_op    = 2'b01;
        req_idx   = 3'd4;
        req_val   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall req_ready", 32'(req_ready), 32'(0));
            check("stall resp_valid", 32'(resp_valid), 32'(1));
        end
        sync();
        resp_ready = 1'b1;
        issue(2'b01, 4, 1'b0, w);
        check("held request waits", 32'(w), 32'(0));
        req_valid = 1'b0;

        sync();
        issue(2'b10, 0, 1'b0, w);
        issue(2'b01, 5, 1'b0, w);
        issue(2'b11, 2, 1'b1, w);
        issue(2'b00, 0, 1'b1, w);
        issue(2'b00, 2, 1'b1, w);
        issue(2'b00, 5, 1'b1, w);
        issue(2'b00, 7, 1'b1, w);
        req_valid = 1'b0;
        @(negedge clk);
        check("a5 assigned", 32'(assigned), 32'hA5);
        check("a5 value", 32'(value), 32'hA5);
        sync();
        issue(2'b10, 6, 1'b0, w);
        req_valid = 1'b0;
        @(negedge clk);
        check("clear assigned", 32'(assigned), 32'h00);
        check("clear value", 32'(value), 32'h00);
        check("clear cnt", 32'(assigned_cnt), 32'd0);

        // Reset in the middle of a stall discards the pending response.
        repeat (2) sync();
        resp_ready = 1'b0;
        issue(2'b00, 1, 1'b1, w);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre-reset resp_valid", 32'(resp_valid), 32'(1));
        sync();
        rst = 1'b1;
        sync();
        @(negedge clk);
        check("mid-stall reset resp_valid", 32'(resp_valid), 32'(0));
        check("mid-stall reset assigned", 32'(assigned), 32'(0));
        sb_q.delete();
        model_clear();
        sync();
        rst        = 1'b0;
        resp_ready = 1'b1;

        rand_rr = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                req_valid = 1'b0;
                sync();
            end else begin
                r = int'($urandom_range(0, 19));
                issue((r < 10) ? 2'b00 : (r < 17) ? 2'b01 : (r < 18) ? 2'b10 : 2'b11,
                      int'($urandom_range(0, NV - 1)), 1'($urandom_range(0, 1)), w);
            end
        end
        req_valid = 1'b0;
        rand_rr   = 1'b0;
        sync();
        resp_ready = 1'b1;
        repeat (4) sync();
        @(negedge clk);
        check_state("final");
        check("scoreboard drained", 32'(sb_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
